// File: rtl/operador_pkg.sv
// Shared types for the arithmetic operator: FSM states and operation codes.
package operador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        SUMA    = 2'b00,
        RESTA   = 2'b01,
        ACUMULA = 2'b10,
        BORRA   = 2'b11
    } op_t;

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector for a level request; pulses for one cycle per low-to-high transition.
module detector_flanco (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic pulso
);

    logic sig_q;
    logic armado;

    // armado stays low until sig has been seen low once after reset, so a
    // request already held high when reset is released never fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q  <= 1'b0;
            armado <= 1'b0;
        end else begin
            sig_q  <= sig;
            armado <= armado | ~sig;
        end
    end

    assign pulso = sig & ~sig_q & armado;

endmodule

// File: rtl/operador_aritmetico.sv
// Multi-cycle unsigned arithmetic unit: add, subtract, saturating accumulate and clear,
// launched by the rising edge of start and sequenced by an IDLE/CALC/FIN FSM.
module operador_aritmetico
    import operador_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic [WIDTH:0]   resultado,
    output logic             desborde,
    output logic             ocupado,
    output logic             listo
);

    state_t           estado;
    state_t           estado_sig;
    logic             lanzar;

    op_t              op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH:0]   acc;

    logic [WIDTH:0]   res_calc;
    logic             desb_calc;
    logic [WIDTH:0]   acc_calc;
    logic [WIDTH+1:0] suma_acc;

    detector_flanco u_detector (
        .clk   (clk),
        .rst   (rst),
        .sig   (start),
        .pulso (lanzar)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = IDLE;
        ocupado    = 1'b0;
        listo      = 1'b0;
        case (estado)
            IDLE: estado_sig = lanzar ? CALC : IDLE;
            CALC: begin
                estado_sig = FIN;
                ocupado    = 1'b1;
            end
            FIN: begin
                estado_sig = IDLE;
                ocupado    = 1'b1;
                listo      = 1'b1;
            end
            default: estado_sig = IDLE;
        endcase
    end

    // Operands are frozen at launch; later input activity cannot reach the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r <= SUMA;
            a_r  <= '0;
            b_r  <= '0;
        end else if (estado == IDLE && lanzar) begin
            op_r <= op_t'(op);
            a_r  <= num1;
            b_r  <= num2;
        end
    end

    always_comb begin
        res_calc  = '0;
        desb_calc = 1'b0;
        acc_calc  = acc;
        suma_acc  = {1'b0, acc} + {2'b00, a_r};
        case (op_r)
            SUMA: begin
                res_calc = {1'b0, a_r} + {1'b0, b_r};
            end
            RESTA: begin
                // The extra MSB of the (WIDTH+1)-bit difference is exactly the borrow.
                res_calc  = {1'b0, a_r} - {1'b0, b_r};
                desb_calc = (a_r < b_r);
            end
            ACUMULA: begin
                if (suma_acc[WIDTH+1]) begin
                    acc_calc  = '1;
                    desb_calc = 1'b1;
                end else begin
                    acc_calc = suma_acc[WIDTH:0];
                end
                res_calc = acc_calc;
            end
            BORRA: begin
                acc_calc = '0;
            end
            default: begin
                res_calc = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resultado <= '0;
            desborde  <= 1'b0;
            acc       <= '0;
        end else if (estado == CALC) begin
            resultado <= res_calc;
            desborde  <= desb_calc;
            acc       <= acc_calc;
        end
    end

endmodule

// File: tb/tb_operador_aritmetico.sv
// Self-checking bench for operador_aritmetico (WIDTH = 12): directed table, corner
// sequences around start handling and reset, then random operations against a model.
module tb_operador_aritmetico;
    import operador_pkg::*;

    localparam int W = 12;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    op_in;
    logic [W-1:0]  num1;
    logic [W-1:0]  num2;
    logic [W:0]    resultado;
    logic          desborde;
    logic          ocupado;
    logic          listo;

    int n_cmp = 0;
    int n_err = 0;
    int listo_cnt = 0;
    int acc_m = 0;

    typedef struct {
        op_t          o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   res;
        logic         desb;
    } vec_t;

    vec_t tabla[$];

    operador_aritmetico #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op_in),
        .num1      (num1),
        .num2      (num2),
        .resultado (resultado),
        .desborde  (desborde),
        .ocupado   (ocupado),
        .listo     (listo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (listo === 1'b1) listo_cnt++;

    task automatic chk(input string nombre, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nombre, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation rules.
    task automatic modelo(input op_t o, input int a, input int b,
                          output int er, output int ed);
        int s;
        er = 0;
        ed = 0;
        case (o)
            SUMA:  er = a + b;
            RESTA: begin
                if (a < b) begin
                    er = a - b + (1 << (W + 1));
                    ed = 1;
                end else begin
                    er = a - b;
                end
            end
            ACUMULA: begin
                s = acc_m + a;
                if (s > (1 << (W + 1)) - 1) begin
                    s  = (1 << (W + 1)) - 1;
                    ed = 1;
                end
                acc_m = s;
                er = s;
            end
            default: begin
                acc_m = 0;
            end
        endcase
    endtask

    task automatic do_op(input op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int er, input int ed, input string tag);
        @(negedge clk);
        op_in = o;
        num1  = a;
        num2  = b;
        start = 1'b1;
        @(posedge clk); #1;
        chk({tag, " calc_listo"}, listo, 0);
        chk({tag, " calc_ocupado"}, ocupado, 1);
        // Disturb inputs after launch; result must use the captured values.
        num1  = W'($urandom);
        num2  = W'($urandom);
        op_in = 2'($urandom);
        @(posedge clk); #1;
        chk({tag, " listo"}, listo, 1);
        chk({tag, " ocupado_fin"}, ocupado, 1);
        chk({tag, " resultado"}, resultado, er);
        chk({tag, " desborde"}, desborde, ed);
        start = 1'b0;
        @(posedge clk); #1;
        chk({tag, " listo_off"}, listo, 0);
        chk({tag, " ocupado_off"}, ocupado, 0);
    endtask

    initial begin
        int er, ed, base;
        logic [W-1:0] ra, rb;
        op_t ro;

        rst   = 1'b1;
        start = 1'b0;
        op_in = 2'b00;
        num1  = '0;
        num2  = '0;

        tabla.push_back('{SUMA,    12'd4095, 12'd4095, 13'h1FFE, 1'b0});
        tabla.push_back('{RESTA,   12'd5,    12'd9,    13'h1FFC, 1'b1});
        tabla.push_back('{RESTA,   12'd9,    12'd5,    13'h0004, 1'b0});
        tabla.push_back('{BORRA,   12'd77,   12'd88,   13'h0000, 1'b0});
        tabla.push_back('{ACUMULA, 12'd4095, 12'd0,    13'd4095, 1'b0});
        tabla.push_back('{ACUMULA, 12'd4095, 12'd1,    13'd8190, 1'b0});
        tabla.push_back('{SUMA,    12'd1,    12'd2,    13'd3,    1'b0});
        tabla.push_back('{ACUMULA, 12'd4095, 12'd0,    13'd8191, 1'b1});
        tabla.push_back('{ACUMULA, 12'd0,    12'd0,    13'd8191, 1'b0});
        tabla.push_back('{BORRA,   12'd0,    12'd0,    13'd0,    1'b0});
        tabla.push_back('{RESTA,   12'd0,    12'd0,    13'd0,    1'b0});
        tabla.push_back('{RESTA,   12'd0,    12'd4095, 13'h1001, 1'b1});
        tabla.push_back('{ACUMULA, 12'd1,    12'd0,    13'd1,    1'b0});

        repeat (3) @(posedge clk);
        #1;
        chk("reset resultado", resultado, 0);
        chk("reset desborde", desborde, 0);
        chk("reset ocupado", ocupado, 0);
        chk("reset listo", listo, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tabla[i]) begin
            modelo(tabla[i].o, int'(tabla[i].a), int'(tabla[i].b), er, ed);
            do_op(tabla[i].o, tabla[i].a, tabla[i].b, int'(tabla[i].res),
                  int'(tabla[i].desb), $sformatf("tabla[%0d]", i));
        end

        // start held high for 10 cycles: a single operation.
        base = listo_cnt;
        @(negedge clk);
        op_in = SUMA; num1 = 12'd100; num2 = 12'd23; start = 1'b1;
        repeat (10) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_start listo_count", listo_cnt - base, 1);
        chk("held_start resultado", resultado, 123);

        // A new rising edge while busy is dropped.
        base = listo_cnt;
        op_in = RESTA; num1 = 12'd10; num2 = 12'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        repeat (5) @(negedge clk);
        chk("busy_edge listo_count", listo_cnt - base, 1);
        chk("busy_edge resultado", resultado, 7);
        start = 1'b0;

        // Reset during CALC aborts; start held through reset must not launch.
        do_op(SUMA, 12'd3, 12'd4, 7, 0, "pre_rst");
        @(negedge clk);
        op_in = SUMA; num1 = 12'd1; num2 = 12'd1; start = 1'b1;
        @(posedge clk); #1;
        chk("rst_calc ocupado_before", ocupado, 1);
        rst = 1'b1;
        #1;
        acc_m = 0;
        chk("rst_calc resultado", resultado, 0);
        chk("rst_calc ocupado", ocupado, 0);
        chk("rst_calc listo", listo, 0);
        base = listo_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_release no_launch", listo_cnt - base, 0);
        chk("rst_release resultado", resultado, 0);
        @(negedge clk);
        start = 1'b0;
        do_op(SUMA, 12'd1, 12'd1, 2, 0, "post_rst");
        modelo(ACUMULA, 5, 0, er, ed);
        do_op(ACUMULA, 12'd5, 12'd0, er, ed, "post_rst_acc");

        for (int k = 0; k < 150; k++) begin
            ro = op_t'(2'($urandom));
            if (ro == BORRA && $urandom_range(0, 2) != 0) ro = ACUMULA;
            ra = ($urandom_range(0, 4) == 0) ? 12'hFFF : W'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? 12'hFFF : W'($urandom);
            modelo(ro, int'(ra), int'(rb), er, ed);
            do_op(ro, ra, rb, er, ed, $sformatf("rand[%0d] op=%0d a=%0d b=%0d", k, ro, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
